// File: rtl/ctrl_mc_if.sv
// ctrl_mc_if: control bundle between the multicycle controller and datapath.
// master = controller (drives controls), slave = datapath/memory side.
interface ctrl_mc_if #(
  parameter int OPW   = 4,
  parameter int MMW   = 4,
  parameter int STATW = 4
);
  logic [OPW-1:0]   OPCODE;
  logic [MMW-1:0]   MM;
  logic [STATW-1:0] STAT;
  logic             MEM_ACK;
  logic             PC_WE;
  logic [1:0]       PC_SEL;
  logic             IR_WE;
  logic             RF_WE;
  logic [1:0]       ALU_OP;
  logic             WB_SEL;
  logic             RD_SEL;
  logic             MEM_REQ;
  logic             MEM_WE;
  logic             BR_TAKEN;
  logic             HALTED;
  logic             FAULT;
  logic [2:0]       STATE;

  modport master (
    input  OPCODE, MM, STAT, MEM_ACK,
    output PC_WE, PC_SEL, IR_WE, RF_WE,
    output ALU_OP, WB_SEL, RD_SEL,
    output MEM_REQ, MEM_WE, BR_TAKEN,
    output HALTED, FAULT, STATE
  );

  modport slave (
    output OPCODE, MM, STAT, MEM_ACK,
    input  PC_WE, PC_SEL, IR_WE, RF_WE,
    input  ALU_OP, WB_SEL, RD_SEL,
    input  MEM_REQ, MEM_WE, BR_TAKEN,
    input  HALTED, FAULT, STATE
  );
endinterface

// File: rtl/ctrl_mc.sv
// ctrl_mc: multicycle fetch/decode/execute/mem/writeback controller.
// Ports: CLK, RST_F (async low), io_bus (ctrl_mc_if.master control bundle).
module ctrl_mc #(
  parameter int OPW   = 4,
  parameter int MMW   = 4,
  parameter int STATW = 4,
  parameter int TMO   = 16
) (
  input  logic      CLK,
  input  logic      RST_F,
  ctrl_mc_if.master io_bus
);
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_START0 = 3'd0,
    S_START1 = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_TERM   = 3'd7
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_fault, w_fault;

  logic w_lod, w_str, w_bra, w_brr;
  logic w_bne, w_alu, w_hlt, w_mem;
  logic w_imm, w_hit, w_taken;

  assign w_lod = io_bus.OPCODE == OPW'(1);
  assign w_str = io_bus.OPCODE == OPW'(2);
  assign w_bra = io_bus.OPCODE == OPW'(4);
  assign w_brr = io_bus.OPCODE == OPW'(5);
  assign w_bne = io_bus.OPCODE == OPW'(6);
  assign w_alu = io_bus.OPCODE == OPW'(8);
  assign w_hlt = io_bus.OPCODE == OPW'(15);
  assign w_mem = w_lod | w_str;
  assign w_imm = io_bus.MM == MMW'(8);
  assign w_hit = |(io_bus.STAT & STATW'(io_bus.MM));

  assign w_taken = (w_bra & ((io_bus.MM == '0) | w_hit))
                 | w_brr
                 | (w_bne & ~w_hit);

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      r_state <= S_START0;
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_fault <= w_fault;
    end
  end

  logic       w_pc_we, w_ir_we, w_rf_we;
  logic [1:0] w_pc_sel, w_alu_op;
  logic       w_wb_sel, w_rd_sel, w_req, w_we;
  logic       w_br, w_halted, w_flt;

  always_comb begin
    w_next   = r_state;
    w_cnt    = '0;
    w_fault  = r_fault;
    w_pc_we  = 1'b0;
    w_pc_sel = 2'b00;
    w_ir_we  = 1'b0;
    w_rf_we  = 1'b0;
    w_alu_op = 2'b00;
    w_wb_sel = 1'b0;
    w_rd_sel = 1'b0;
    w_req    = 1'b0;
    w_we     = 1'b0;
    w_br     = 1'b0;
    w_halted = 1'b0;
    w_flt    = 1'b0;
    case (r_state)
      S_START0: w_next = S_START1;
      S_START1: w_next = S_FETCH;
      S_FETCH: begin
        w_ir_we = 1'b1;
        w_pc_we = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        if (w_hlt) begin
          w_next  = S_TERM;
          w_fault = 1'b0;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_next = S_MEM;
        if (w_alu) w_alu_op = {1'b0, w_imm};
        if (w_mem) w_alu_op = 2'b01;
        if (w_taken) begin
          w_br     = 1'b1;
          w_pc_we  = 1'b1;
          w_pc_sel = w_bra ? 2'b01 : 2'b10;
        end
      end
      S_MEM: begin
        if (!w_mem) begin
          w_next = S_WB;
        end else begin
          w_req = 1'b1;
          w_we  = w_str;
          // Ack on the final allowed cycle still wins over the timeout.
          if (io_bus.MEM_ACK) begin
            w_next = S_WB;
          end else if (r_cnt == CW'(TMO - 1)) begin
            w_next  = S_TERM;
            w_fault = 1'b1;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      S_WB: begin
        w_next = S_FETCH;
        if (w_alu) begin
          w_rf_we  = 1'b1;
          w_rd_sel = w_imm;
        end
        if (w_lod) begin
          w_rf_we  = 1'b1;
          w_wb_sel = 1'b1;
        end
      end
      S_TERM: begin
        w_halted = ~r_fault;
        w_flt    = r_fault;
      end
      default: w_next = S_START0;
    endcase
  end

  assign io_bus.PC_WE    = w_pc_we;
  assign io_bus.PC_SEL   = w_pc_sel;
  assign io_bus.IR_WE    = w_ir_we;
  assign io_bus.RF_WE    = w_rf_we;
  assign io_bus.ALU_OP   = w_alu_op;
  assign io_bus.WB_SEL   = w_wb_sel;
  assign io_bus.RD_SEL   = w_rd_sel;
  assign io_bus.MEM_REQ  = w_req;
  assign io_bus.MEM_WE   = w_we;
  assign io_bus.BR_TAKEN = w_br;
  assign io_bus.HALTED   = w_halted;
  assign io_bus.FAULT    = w_flt;
  assign io_bus.STATE    = r_state;
endmodule

// File: doc/ctrl_mc.md
Name: ctrl_mc

Overview:
- Parametrised multicycle control FSM for the group's CPU datapath; successor to the basic fetch/decode/execute/mem/writeback controller.
- Sequences fetch, decode, execute, mem and writeback for ALU, load/store, branch, NOOP and HLT instructions.
- Drives PC, IR, register-file, ALU and memory control signals.
- Adds a memory request/acknowledge handshake with a timeout watchdog, and terminal HALT and FAULT states.

Parameters:
- OPW, 4, opcode width (IR[31:28]).
- MMW, 4, addressing-mode / condition-mask width (IR[27:24]).
- STATW, 4, status flag width; must equal MMW.
- TMO, 16, maximum MEM-state wait cycles before FAULT (≥2).

Ports:
- CLK  in  1  clock, rising edge
- RST_F  in  1  reset, asynchronous, active-low
- OPCODE  in  OPW  instruction opcode, from IR; stable from DECODE until the next FETCH
- MM  in  MMW  mode field; 8 = immediate; condition mask for branches
- STAT  in  STATW  ALU status flags, sampled in EXECUTE
- MEM_ACK  in  1  memory completion for the current request
- PC_WE  out  1  PC write enable
- PC_SEL  out  2  PC source: 00 = PC+1, 01 = absolute target, 10 = PC-relative target
- IR_WE  out  1  instruction register load
- RF_WE  out  1  register-file write enable
- ALU_OP  out  2  00 = register operand, 01 = immediate operand
- WB_SEL  out  1  writeback source: 0 = ALU, 1 = memory data
- RD_SEL  out  1  destination select: 1 when MM == 8
- MEM_REQ  out  1  memory access request
- MEM_WE  out  1  memory write (store)
- BR_TAKEN  out  1  branch resolved taken (EXECUTE only)
- HALTED  out  1  sticky halt indicator
- FAULT  out  1  sticky memory-timeout indicator
- STATE  out  3  present-state encoding, for debug

Behaviour:
- State register and timeout counter update on posedge CLK. RST_F low asynchronously forces START0 and clears the counter.
- State encoding: START0 = 0, START1 = 1, FETCH = 2, DECODE = 3, EXECUTE = 4, MEM = 5, WRITEBACK = 6, TERM = 7. TERM is the shared terminal state; a 1-bit sticky register records whether it was entered as HALT or FAULT.
- Transitions:
  - START0 → START1 → FETCH → DECODE.
  - DECODE → TERM(halt) if OPCODE == 15; otherwise → EXECUTE.
  - EXECUTE → MEM → WRITEBACK → FETCH.
  - TERM holds until reset.
- Opcode decode:
  - NOOP = 0, LOD = 1, STR = 2, BRA = 4, BRR = 5, BNE = 6, ALU = 8, HLT = 15.
  - Any other opcode is treated as NOOP: full 5-cycle pass with no side effects.
- Outputs are combinational from present state plus OPCODE/MM/STAT. Every output is 0 unless listed below; all outputs are 0 during reset, START0 and START1.
- FETCH: IR_WE = 1, PC_WE = 1, PC_SEL = 00.
- DECODE: no outputs asserted.
- EXECUTE:
  - ALU: ALU_OP = 01 if MM == 8, else 00.
  - LOD/STR: ALU_OP = 01 (address = base + immediate).
  - BRA: taken if MM == 0 or (STAT & MM) != 0; target absolute, PC_SEL = 01.
  - BRR: always taken; PC_SEL = 10.
  - BNE: taken if (STAT & MM) == 0; PC_SEL = 10.
  - When a branch is taken: BR_TAKEN = 1 and PC_WE = 1 for this one cycle only.
- MEM:
  - LOD/STR: MEM_REQ = 1 (MEM_WE = 1 for STR), held every cycle until MEM_ACK is sampled high. MEM_ACK high in a MEM cycle → WRITEBACK at the next edge (1-cycle minimum).
  - Counter increments each MEM cycle without ack. Ack absent on the TMO-th consecutive MEM cycle → TERM(fault).
  - Ack on that same final cycle wins: go to WRITEBACK, no fault.
  - Counter clears on leaving MEM.
  - Non-memory opcodes: MEM lasts exactly 1 cycle, MEM_ACK ignored.
- WRITEBACK:
  - ALU: RF_WE = 1, WB_SEL = 0, RD_SEL = (MM == 8).
  - LOD: RF_WE = 1, WB_SEL = 1.
  - Others: no writes.
- TERM: HALTED = 1 (halt) or FAULT = 1 (fault); never both; no other outputs asserted.
- MEM_ACK outside MEM is ignored. RST_F asserted mid-instruction or mid-MEM aborts immediately; MEM_REQ drops asynchronously.
- Latency: 5 cycles per instruction after the 2 start cycles; LOD/STR add (ack wait − 1) cycles.

Test Plan:
- Reset, then ALU with MM = 8 → STATE 0,1,2,3,4,5,6,2. ALU_OP = 01 in EXECUTE; RF_WE = 1 and RD_SEL = 1 only in WRITEBACK.
- LOD with MEM_ACK delayed 3 cycles → MEM_REQ high 3 cycles, MEM_WE = 0. WRITEBACK has RF_WE = 1, WB_SEL = 1. Next FETCH on the correct cycle.
- BNE with MM = 4'b0001: STAT = 0001 → BR_TAKEN = 0, PC_WE = 0 in EXECUTE. STAT = 0000 → BR_TAKEN = 1, PC_WE = 1, PC_SEL = 10.
- STR with MEM_ACK never asserted, TMO = 16 → FAULT = 1 after the 16th MEM cycle, STATE = 7, sticky. Repeat with ack on the 16th cycle → no fault.
- HLT (opcode 15) → HALTED = 1 the cycle after DECODE, STATE = 7, no RF_WE/PC_WE. RST_F pulse → STATE = 0, HALTED = 0.
- RST_F asserted mid-MEM of a STR → MEM_REQ and MEM_WE drop immediately; restart from START0 with clean counter.
